// File: rtl/sata_oob_device.sv
// Device-side SATA OOB responder: answers a host COMRESET with COMINIT, trades COMWAKE,
// then transmits ALIGN until host ALIGNs arrive and declares the link up.
module sata_oob_device #(
   parameter logic [19:0] AWAKE_TIMEOUT = 20'd800000,
   parameter logic [15:0] ALIGN_TIMEOUT = 16'd8192,
   parameter logic [3:0]  MAX_RETRIES   = 4'd3
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_phy_ready,
   input  logic i_rx_comreset,
   input  logic i_rx_comwake,
   input  logic i_rx_align,
   input  logic i_tx_comfinish,
   output logic o_tx_cominit,
   output logic o_tx_comwake,
   output logic o_tx_elecidle,
   output logic o_tx_align,
   output logic o_link_up,
   output logic o_err
);

   typedef enum logic [3:0] {
      IDLE              = 4'd0,
      SEND_COMINIT      = 4'd1,
      WAIT_COMINIT_DONE = 4'd2,
      AWAIT_COMWAKE     = 4'd3,
      WAIT_WAKE_END     = 4'd4,
      SEND_COMWAKE      = 4'd5,
      WAIT_COMWAKE_DONE = 4'd6,
      SEND_ALIGN        = 4'd7,
      READY             = 4'd8
   } state_t;

   localparam logic [19:0] TIMER_MAX   = 20'hFFFFF;
   localparam logic [19:0] AWAKE_LAST  = AWAKE_TIMEOUT - 20'd1;
   localparam logic [19:0] ALIGN_LAST  = {4'd0, ALIGN_TIMEOUT} - 20'd1;
   localparam logic [4:0]  RETRY_LIMIT = {1'b0, MAX_RETRIES} + 5'd1;

   state_t      state_q, state_d;
   logic [19:0] timer_q, timer_d;
   logic [4:0]  retry_q, retry_d;
   logic        err_q, err_d;
   logic        comreset_q;
   logic        comreset_fall_q;
   logic        tx_cominit_q, tx_comwake_q, tx_elecidle_q, tx_align_q, link_up_q;

   logic        comreset_rise_s;
   logic [4:0]  retry_inc_s;
   logic        give_up_s;
   state_t      fail_state_s;

   assign comreset_rise_s = i_rx_comreset & ~comreset_q;
   assign retry_inc_s     = retry_q + 5'd1;
   assign give_up_s       = (retry_inc_s >= RETRY_LIMIT);
   assign fail_state_s    = give_up_s ? IDLE : SEND_COMINIT;

   // Next-state, retry and error logic; a COMRESET rising edge outranks everything else.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      err_d   = err_q;
      if (comreset_rise_s) begin
         state_d = IDLE;
         retry_d = 5'd0;
         err_d   = 1'b0;
      end else if (!i_phy_ready) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // Only answer once the host burst has ended.
               if (comreset_fall_q) state_d = SEND_COMINIT;
               else                 state_d = IDLE;
            end
            SEND_COMINIT: state_d = WAIT_COMINIT_DONE;
            WAIT_COMINIT_DONE: begin
               if (i_tx_comfinish) state_d = AWAIT_COMWAKE;
               else                state_d = WAIT_COMINIT_DONE;
            end
            AWAIT_COMWAKE: begin
               if (i_rx_comwake) begin
                  state_d = WAIT_WAKE_END;
               end else if (timer_q == AWAKE_LAST) begin
                  state_d = fail_state_s;
                  retry_d = retry_inc_s;
                  err_d   = err_q | give_up_s;
               end else begin
                  state_d = AWAIT_COMWAKE;
               end
            end
            WAIT_WAKE_END: begin
               if (!i_rx_comwake) state_d = SEND_COMWAKE;
               else               state_d = WAIT_WAKE_END;
            end
            SEND_COMWAKE: state_d = WAIT_COMWAKE_DONE;
            WAIT_COMWAKE_DONE: begin
               if (i_tx_comfinish) state_d = SEND_ALIGN;
               else                state_d = WAIT_COMWAKE_DONE;
            end
            SEND_ALIGN: begin
               if (i_rx_align) begin
                  state_d = READY;
               end else if (timer_q == ALIGN_LAST) begin
                  state_d = fail_state_s;
                  retry_d = retry_inc_s;
                  err_d   = err_q | give_up_s;
               end else begin
                  state_d = SEND_ALIGN;
               end
            end
            READY: begin
               state_d = READY;
               retry_d = 5'd0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Shared timeout timer: restarts on any state change or COMRESET, saturates at full scale.
   always_comb begin
      timer_d = timer_q;
      if (comreset_rise_s || (state_d != state_q)) begin
         timer_d = 20'd0;
      end else if (timer_q == TIMER_MAX) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + 20'd1;
      end
   end

   // State, counters, COMRESET edge history and outputs registered from the next state.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q         <= IDLE;
         timer_q         <= 20'd0;
         retry_q         <= 5'd0;
         err_q           <= 1'b0;
         comreset_q      <= 1'b0;
         comreset_fall_q <= 1'b0;
         tx_cominit_q    <= 1'b0;
         tx_comwake_q    <= 1'b0;
         tx_elecidle_q   <= 1'b1;
         tx_align_q      <= 1'b0;
         link_up_q       <= 1'b0;
      end else begin
         state_q         <= state_d;
         timer_q         <= timer_d;
         retry_q         <= retry_d;
         err_q           <= err_d;
         comreset_q      <= i_rx_comreset;
         comreset_fall_q <= comreset_q & ~i_rx_comreset;
         tx_cominit_q    <= (state_d == SEND_COMINIT);
         tx_comwake_q    <= (state_d == SEND_COMWAKE);
         tx_elecidle_q   <= ~((state_d == SEND_ALIGN) || (state_d == READY));
         tx_align_q      <= (state_d == SEND_ALIGN);
         link_up_q       <= (state_d == READY);
      end
   end

   assign o_tx_cominit  = tx_cominit_q;
   assign o_tx_comwake  = tx_comwake_q;
   assign o_tx_elecidle = tx_elecidle_q;
   assign o_tx_align    = tx_align_q;
   assign o_link_up     = link_up_q;
   assign o_err         = err_q;

endmodule

// File: tb/tb_sata_oob_device.sv
// Scoreboard bench for sata_oob_device: stimulus queues expected output-vector changes
// with their cycle spacing; a monitor pops and compares on every output change.
module tb_sata_oob_device;

   logic clk;
   logic rst_n;
   logic phy_ready, comreset, comwake, rx_align, comfinish;
   logic tx_cominit, tx_comwake, tx_elecidle, tx_align, link_up, err;
   logic [5:0] outs;

   localparam int CI = 0, CW = 1, EI = 2, AL = 3, LU = 4, ER = 5;
   localparam logic [5:0] V_IDLE = 6'b000100;
   localparam logic [5:0] V_CI   = 6'b000101;
   localparam logic [5:0] V_CW   = 6'b000110;
   localparam logic [5:0] V_AL   = 6'b001000;
   localparam logic [5:0] V_LU   = 6'b010000;
   localparam logic [5:0] V_ERR  = 6'b100100;

   typedef struct {
      logic [5:0] vec;
      int         gap;
      string      name;
   } ev_t;

   ev_t exp_q[$];
   int  n_vec = 0;
   int  n_bad = 0;

   sata_oob_device #(
      .AWAKE_TIMEOUT(20'd100),
      .ALIGN_TIMEOUT(16'd50),
      .MAX_RETRIES  (4'd3)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_phy_ready   (phy_ready),
      .i_rx_comreset (comreset),
      .i_rx_comwake  (comwake),
      .i_rx_align    (rx_align),
      .i_tx_comfinish(comfinish),
      .o_tx_cominit  (tx_cominit),
      .o_tx_comwake  (tx_comwake),
      .o_tx_elecidle (tx_elecidle),
      .o_tx_align    (tx_align),
      .o_link_up     (link_up),
      .o_err         (err)
   );

   assign outs = {err, link_up, tx_align, tx_elecidle, tx_comwake, tx_cominit};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic [5:0] v, input int gap, input string name);
      ev_t e;
      e.vec  = v;
      e.gap  = gap;
      e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: outputs %b, required %b", name, got, want);
      end
   endtask

   task automatic wait_out(input int idx, input string name);
      int n;
      n = 0;
      while (outs[idx] !== 1'b1 && n < 400) begin
         tick();
         n++;
      end
      if (outs[idx] !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_%s: output bit still %b after %0d cycles, required 1", name, outs[idx], n);
      end
   endtask

   task automatic host_comreset();
      comreset = 1'b1;
      repeat (10) tick();
      comreset = 1'b0;
   endtask

   task automatic host_comwake();
      comwake = 1'b1;
      repeat (10) tick();
      comwake = 1'b0;
   endtask

   task automatic finish_after(input int n);
      repeat (n) tick();
      comfinish = 1'b1;
      tick();
      comfinish = 1'b0;
   endtask

   // Answer a COMINIT request through to ALIGN transmission (or stop in WAIT_COMWAKE_DONE).
   task automatic answer_to_align(input bit stop_at_done, input string tag);
      expect_ev(V_CW, 31, {tag, "_comwake"});
      expect_ev(V_IDLE, 1, {tag, "_comwake_end"});
      if (!stop_at_done) expect_ev(V_AL, 20, {tag, "_align"});
      wait_out(CI, {tag, "_cominit"});
      finish_after(20);
      host_comwake();
      wait_out(CW, {tag, "_comwake"});
      if (!stop_at_done) begin
         finish_after(20);
         wait_out(AL, {tag, "_align"});
      end
   endtask

   task automatic go_ready(input string tag);
      expect_ev(V_LU, 6, {tag, "_link_up"});
      repeat (5) tick();
      rx_align = 1'b1;
      wait_out(LU, {tag, "_link_up"});
      rx_align = 1'b0;
   endtask

   initial begin : monitor
      logic [5:0] last;
      int         nc;
      int         last_nc;
      ev_t        e;
      last    = V_IDLE;
      nc      = 0;
      last_nc = 0;
      forever begin
         @(negedge clk);
         nc++;
         if (outs !== last) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_change: outputs %b, required %b (no change expected)", outs, last);
            end else begin
               e = exp_q.pop_front();
               if (outs !== e.vec || (e.gap >= 0 && (nc - last_nc) != e.gap)) begin
                  n_bad++;
                  $display("FAIL %s: outputs %b after %0d cycles, required %b after %0d cycles",
                           e.name, outs, nc - last_nc, e.vec, e.gap);
               end
            end
            last    = outs;
            last_nc = nc;
         end
      end
   end

   initial begin : stim
      rst_n     = 1'b1;
      phy_ready = 1'b0;
      comreset  = 1'b0;
      comwake   = 1'b0;
      rx_align  = 1'b0;
      comfinish = 1'b0;
      #1 rst_n = 1'b0;
      #2;
      check("reset_outputs", outs, V_IDLE);
      repeat (3) tick();
      rst_n     = 1'b1;
      phy_ready = 1'b1;
      repeat (3) tick();

      // Normal bring-up
      expect_ev(V_CI, -1, "a_cominit");
      expect_ev(V_IDLE, 1, "a_cominit_end");
      host_comreset();
      answer_to_align(1'b0, "a");
      go_ready("a");

      // COMRESET in READY, then an ALIGN timeout retry
      expect_ev(V_IDLE, -1, "b_comreset_in_ready");
      expect_ev(V_CI, 11, "b_cominit");
      expect_ev(V_IDLE, 1, "b_cominit_end");
      host_comreset();
      answer_to_align(1'b0, "b1");
      expect_ev(V_CI, 50, "b_align_timeout_cominit");
      expect_ev(V_IDLE, 1, "b_retry_cominit_end");
      answer_to_align(1'b0, "b2");

      // COMRESET in SEND_ALIGN
      repeat (3) tick();
      expect_ev(V_IDLE, 4, "c_comreset_in_align");
      expect_ev(V_CI, 11, "c_cominit");
      expect_ev(V_IDLE, 1, "c_cominit_end");
      host_comreset();

      // Host never sends COMWAKE: four COMINITs then error
      for (int i = 0; i < 3; i++) begin
         wait_out(CI, "d_cominit");
         finish_after(20);
         expect_ev(V_CI, 120, "d_retry_cominit");
         expect_ev(V_IDLE, 1, "d_retry_cominit_end");
      end
      wait_out(CI, "d_last_cominit");
      finish_after(20);
      expect_ev(V_ERR, 120, "d_err_set");
      wait_out(ER, "d_err");
      repeat (3) tick();

      // Phy not ready: error kept, COMRESET clears it, no COMINIT answer
      phy_ready = 1'b0;
      repeat (5) tick();
      expect_ev(V_IDLE, -1, "e_comreset_clears_err");
      host_comreset();
      repeat (20) tick();
      phy_ready = 1'b1;
      repeat (5) tick();
      expect_ev(V_CI, -1, "e_cominit");
      expect_ev(V_IDLE, 1, "e_cominit_end");
      host_comreset();
      answer_to_align(1'b0, "e");
      go_ready("e");
      expect_ev(V_IDLE, -1, "e_phy_drop_in_ready");
      phy_ready = 1'b0;
      repeat (5) tick();
      phy_ready = 1'b1;
      repeat (5) tick();

      // Async reset in WAIT_COMWAKE_DONE, then in READY
      expect_ev(V_CI, -1, "f_cominit");
      expect_ev(V_IDLE, 1, "f_cominit_end");
      host_comreset();
      answer_to_align(1'b1, "f");
      repeat (3) tick();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("f_async_reset_wcd", outs, V_IDLE);
      tick();
      rst_n = 1'b1;
      comfinish = 1'b1;
      tick();
      comfinish = 1'b0;
      repeat (10) tick();
      expect_ev(V_CI, -1, "g_cominit");
      expect_ev(V_IDLE, 1, "g_cominit_end");
      host_comreset();
      answer_to_align(1'b0, "g");
      go_ready("g");
      expect_ev(V_IDLE, -1, "g_async_reset_ready_event");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("g_async_reset_ready", outs, V_IDLE);
      tick();
      rst_n = 1'b1;
      repeat (5) tick();

      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drained: %0d expected events outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
